mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter that shares the single-port byte-addressed data memory between the CPU data port (requester 0) and a secondary master such as the UART loader or a debug port (requester 1). It sits between the requesters and the memory instance inside the memory controller. It applies round-robin priority with an optional bounded lock for atomic sequences, and routes one-cycle-latency read data back to the requester that issued the read.

## Interface
- `MAX_LOCK`, default 16: maximum consecutive cycles one requester may hold a lock before forced rotation.
- `clk` in 1: single clock, rising edge.
- `Rst` in 1: synchronous, active-high reset.
- `req[1:0]` in 2: per-requester access request.
- `lock[1:0]` in 2: per-requester lock; keeps ownership while `req` is held.
- `wea[1:0]` in 2: per-requester write enable (1 = write).
- `en0`, `en1` in 4 each: byte enables.
- `addr0`, `addr1` in 32 each: byte addresses.
- `din0`, `din1` in 32 each: write data.
- `gnt[1:0]` out 2: access issued this cycle (one-hot or zero).
- `rvalid[1:0]` out 2: read data valid for the requester.
- `rdata` out 32: read data, shared and qualified by `rvalid`.
- `mem_wea` out 1, `mem_en` out 4, `mem_addr` out 12, `mem_din` out 32: memory command.
- `mem_dout` in 32: memory read data, valid the cycle after the command.

## Operation
- State: `owner` (1 bit, last granted requester), `locked` (1 bit), `lock_cnt` (`$clog2(MAX_LOCK+1)` bits), `rd_pend` (1 bit), `rd_id` (1 bit), `rd_oob` (1 bit).
- FSM states:
  - `IDLE` (no lock held).
  - `LOCKED` (`owner` holds the memory).
- Arbitration in `IDLE`:
  - If exactly one `req` is high, that requester is granted.
  - If both are high, the requester that is not `owner` is granted (round-robin).
- Transitions:
  - `IDLE` → `LOCKED` when the granted requester has `lock` high.
  - `LOCKED` → `IDLE` when the owner drops `req` or `lock`, or when `lock_cnt` reaches `MAX_LOCK` while the other requester's `req` is high.
- Forced release: the other requester is granted in the same cycle the lock is broken.
- While `LOCKED`, only `owner` can be granted. The other requester waits with `req` held.
- Requester protocol: hold `req`, `wea`, `en`, `addr`, and `din` stable until `gnt` is seen. An access completes in the cycle `gnt` is high.
- Memory command: the granted requester's fields are driven combinationally.
  - `mem_addr` = `addr[11:0]`.
  - `mem_en` = `en` if `addr[31:12] == 0`, else `4'b0000`.
  - `mem_wea` = `wea` only when granted.
  - With no grant, `mem_en` = 0 and `mem_wea` = 0.
- Out-of-range accesses (`addr[31:12] != 0`):
  - They are still granted.
  - Writes are dropped.
  - Reads return `rdata` = 0.
- Read return: a granted read (`wea` = 0) sets `rd_pend`, `rd_id`, and `rd_oob`.
  - Next cycle: `rvalid[rd_id]` = 1 and `rdata` = `rd_oob ? 0 : mem_dout`.
  - When no read is pending, `rdata` = 0.
- `lock_cnt` behaviour:
  - Increments each granted cycle in `LOCKED`.
  - Clears on entry to `IDLE` or on an ownership change.
  - Saturates at `MAX_LOCK`.

## Timing
- Reset values: `gnt` = 0, `rvalid` = 0, `rdata` = 0, `mem_en` = 0, `mem_wea` = 0, `owner` = 1 (so requester 0 wins the first contention), FSM = `IDLE`, all counters 0.
- Grant latency:
  - 0 cycles when uncontended (`gnt` is combinational).
  - At most 1 cycle under contention without lock.
  - At most `MAX_LOCK` + 1 cycles with lock.
- Read latency: `rvalid` exactly 1 cycle after `gnt`.
- Back-to-back reads: one grant per cycle, with `rvalid` pipelined one behind.
- Write followed by a read of the same address on the next cycle returns the new data.
- `Rst` asserted mid-operation: a pending `rvalid` is suppressed, the lock is released, and the FSM returns to `IDLE` on the next edge.
- `req` dropped without a grant: legal, with no side effects.

## Structure
- A shared package (`mem_arb_pkg`) holds:
  - the FSM enum `arb_state_t` (`IDLE`, `LOCKED`);
  - requester index constants `REQ_CPU` = 0 and `REQ_AUX` = 1;
  - `MEM_ADDR_W` = 12.
- One sub-module, `rr_pick2`, which is purely combinational: takes `req[1:0]` and `owner`, and returns a one-hot pick.
- The top level holds the FSM, the counters, the read-return pipeline, and the output muxing.

## Test plan
- Reset, then `req0` read at address `0x010` (memory preloaded with `0xDEADBEEF`) → `gnt` = `01` the same cycle; `rvalid` = `01` and `rdata` = `0xDEADBEEF` the next cycle.
- Both requesters request writes every cycle for 4 cycles → grants alternate `01`, `10`, `01`, `10`.
- `req1` write with `lock` = 1 held for 20 cycles while `req0` is pending, `MAX_LOCK` = 16 → `req1` is granted for 16 cycles, then `gnt` = `01` in cycle 17.
- `req0` write to `0xAAAAA008` with data `0x12345678` → granted, `mem_en` = 0; a read of the same address returns `rdata` = 0 with `rvalid`.
- `req0` read granted, then `Rst` pulsed in the following cycle → `rvalid` stays 0, `gnt` = 0, and the next contention is won by requester 0.
- `req0` writes `0xCAFEF00D` with `en` = `4'b0011` at `0x020` (old value `0xFFFFFFFF`), then `req1` reads the same address → `rdata` = `0xFFFFF00D` on `rvalid[1]`.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester data-memory arbiter.
package mem_arb_pkg;

    // Arbiter FSM: IDLE arbitrates freely, LOCKED keeps the owner on the memory.
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Requester indices.
    localparam int REQ_CPU = 0;
    localparam int REQ_AUX = 1;

    // Byte-address width of the attached memory (4 KiB).
    localparam int MEM_ADDR_W = 12;

    // An address hits the memory only when every bit above the memory window is zero.
    function automatic logic addr_in_range(input logic [31:0] addr);
        return (addr[31:MEM_ADDR_W] == '0);
    endfunction

    // One-hot grant vector for a single requester index.
    function automatic logic [1:0] onehot2(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational round-robin pick between two requesters.
// When both request, the one that was not granted last (not owner) wins.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       owner,
    output logic [1:0] pick
);

    // Single requester wins outright; contention goes to the non-owner.
    always_comb begin
        pick = 2'b00;
        case (req)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = owner ? 2'b01 : 2'b10;
            default: pick = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the single-port data memory.
// Round-robin between the CPU port and an auxiliary master, with a bounded
// lock for atomic sequences and a one-cycle read-return pipeline.
//
// Handshake: a requester raises req with wea/en/addr/din and holds them
// stable until it sees gnt; the access completes in the gnt cycle. A read
// returns on rvalid[id] exactly one cycle after its gnt, with rdata shared
// between both requesters and meaningful only under rvalid.
//
// MAX_LOCK must be at least 1.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_LOCK = 16
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic [1:0]  req,
    input  logic [1:0]  lock,
    input  logic [1:0]  wea,
    input  logic [3:0]  en0,
    input  logic [3:0]  en1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] din0,
    input  logic [31:0] din1,
    output logic [1:0]  gnt,
    output logic [1:0]  rvalid,
    output logic [31:0] rdata,
    output logic        mem_wea,
    output logic [3:0]  mem_en,
    output logic [11:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout,
    output logic        arb_state
);

    localparam int CNT_W = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic             owner;
    logic [CNT_W-1:0] lock_cnt;
    logic [CNT_W-1:0] lock_cnt_nxt;
    logic [1:0]       rr_pick;
    logic [1:0]       gnt_raw;

    logic             rd_pend;
    logic             rd_id;
    logic             rd_oob;

    logic             granted;
    logic             sel;
    logic             sel_wea;
    logic [3:0]       sel_en;
    logic [31:0]      sel_addr;
    logic [31:0]      sel_din;
    logic             sel_in_range;

    // Debug view of the FSM state.
    assign arb_state = state;

    rr_pick2 u_pick (
        .req   (req),
        .owner (owner),
        .pick  (rr_pick)
    );

    // Next-state, grant and lock-counter logic.
    always_comb begin
        state_nxt    = state;
        lock_cnt_nxt = lock_cnt;
        gnt_raw      = 2'b00;
        case (state)
            IDLE: begin
                gnt_raw      = rr_pick;
                lock_cnt_nxt = '0;
                // The entry grant is the first locked cycle, so the count starts at 1.
                if ((rr_pick != 2'b00) && lock[rr_pick[1]]) begin
                    state_nxt    = LOCKED;
                    lock_cnt_nxt = CNT_W'(1);
                end
            end
            LOCKED: begin
                if (!req[owner] || !lock[owner]) begin
                    // Owner releases; a final unlocked access by the owner still goes through.
                    state_nxt    = IDLE;
                    lock_cnt_nxt = '0;
                    if (req[owner]) begin
                        gnt_raw = onehot2(owner);
                    end
                end else if ((lock_cnt == CNT_MAX) && req[~owner]) begin
                    // Lock budget exhausted with the other side waiting: hand over now.
                    state_nxt    = IDLE;
                    lock_cnt_nxt = '0;
                    gnt_raw      = onehot2(~owner);
                end else begin
                    gnt_raw = onehot2(owner);
                    if (lock_cnt != CNT_MAX) begin
                        lock_cnt_nxt = lock_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_nxt    = IDLE;
                lock_cnt_nxt = '0;
            end
        endcase
    end

    // Reset blanks the grant immediately so no access is issued during reset.
    assign gnt     = Rst ? 2'b00 : gnt_raw;
    assign granted = (gnt != 2'b00);

    // FSM state, owner and lock counter registers.
    always_ff @(posedge clk) begin
        if (Rst) begin
            state    <= IDLE;
            owner    <= 1'b1;
            lock_cnt <= '0;
        end else begin
            state    <= state_nxt;
            lock_cnt <= lock_cnt_nxt;
            if (granted) begin
                owner <= gnt[1];
            end
        end
    end

    // Select the granted requester's command fields.
    always_comb begin
        sel      = gnt[1];
        sel_wea  = sel ? wea[REQ_AUX] : wea[REQ_CPU];
        sel_en   = sel ? en1   : en0;
        sel_addr = sel ? addr1 : addr0;
        sel_din  = sel ? din1  : din0;
    end

    assign sel_in_range = addr_in_range(sel_addr);

    // Memory command: out-of-range accesses are granted but never enable the memory.
    always_comb begin
        mem_addr = sel_addr[MEM_ADDR_W-1:0];
        mem_din  = sel_din;
        mem_wea  = granted & sel_wea;
        mem_en   = (granted && sel_in_range) ? sel_en : 4'b0000;
    end

    // Read-return pipeline: remember who read and whether it missed the memory.
    always_ff @(posedge clk) begin
        if (Rst) begin
            rd_pend <= 1'b0;
            rd_id   <= 1'b0;
            rd_oob  <= 1'b0;
        end else begin
            rd_pend <= granted && !sel_wea;
            rd_id   <= sel;
            rd_oob  <= !sel_in_range;
        end
    end

    // Route read data back; a reset in the return cycle suppresses it.
    always_comb begin
        rvalid = 2'b00;
        rdata  = 32'h0;
        if (rd_pend && !Rst) begin
            rvalid = onehot2(rd_id);
            rdata  = rd_oob ? 32'h0 : mem_dout;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a behavioural byte-enable memory.
module tb_mem_arbiter;

    logic        clk;
    logic        Rst;
    logic        preload;
    logic [1:0]  req;
    logic [1:0]  lock;
    logic [1:0]  wea;
    logic [3:0]  en0;
    logic [3:0]  en1;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [31:0] din0;
    logic [31:0] din1;
    logic [1:0]  gnt;
    logic [1:0]  rvalid;
    logic [31:0] rdata;
    logic        mem_wea;
    logic [3:0]  mem_en;
    logic [11:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic        arb_state;

    int checks;
    int errors;

    logic [31:0] mem [0:1023];

    mem_arbiter #(.MAX_LOCK(16)) dut (
        .clk       (clk),
        .Rst       (Rst),
        .req       (req),
        .lock      (lock),
        .wea       (wea),
        .en0       (en0),
        .en1       (en1),
        .addr0     (addr0),
        .addr1     (addr1),
        .din0      (din0),
        .din1      (din1),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .mem_wea   (mem_wea),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout),
        .arb_state (arb_state)
    );

    // Clock and memory model.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
            mem[2] <= 32'h5A5A5A5A;
            mem[4] <= 32'hDEADBEEF;
            mem[8] <= 32'hFFFFFFFF;
            mem_dout <= 32'h0;
        end else if (mem_en != 4'b0000) begin
            if (mem_wea) begin
                for (int b = 0; b < 4; b++)
                    if (mem_en[b]) mem[mem_addr[11:2]][8*b +: 8] <= mem_din[8*b +: 8];
            end else begin
                mem_dout <= mem[mem_addr[11:2]];
            end
        end
    end

    // Driver tasks.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        req = 2'b00; lock = 2'b00; wea = 2'b00;
        en0 = 4'h0; en1 = 4'h0; addr0 = 32'h0; addr1 = 32'h0; din0 = 32'h0; din1 = 32'h0;
    endtask

    task automatic set_req(input int idx, input logic l, input logic w,
                           input logic [3:0] e, input logic [31:0] a, input logic [31:0] d);
        req[idx] = 1'b1; lock[idx] = l; wea[idx] = w;
        if (idx == 0) begin en0 = e; addr0 = a; din0 = d; end
        else begin en1 = e; addr1 = a; din1 = d; end
    endtask

    task automatic test_reset();
        Rst = 1'b1; preload = 1'b1; clear_all();
        set_req(0, 1'b0, 1'b0, 4'hF, 32'h10, 32'h0);
        repeat (3) step();
        #1;
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b expected 00", gnt); end
        checks++; if (mem_en !== 4'h0) begin errors++; $display("FAIL reset_mem_en: got %h expected 0", mem_en); end
        checks++; if (mem_wea !== 1'b0) begin errors++; $display("FAIL reset_mem_wea: got %b expected 0", mem_wea); end
        checks++; if (rvalid !== 2'b00) begin errors++; $display("FAIL reset_rvalid: got %b expected 00", rvalid); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
        checks++; if (arb_state !== 1'b0) begin errors++; $display("FAIL reset_state: got %b expected 0", arb_state); end
        Rst = 1'b0; preload = 1'b0; clear_all();
        step();
        checks++; if (rvalid !== 2'b00 || gnt !== 2'b00) begin errors++; $display("FAIL post_reset_idle: got gnt %b rvalid %b expected 00 00", gnt, rvalid); end
    endtask

    task automatic test_rr_writes();
        logic [1:0] exp_g [4];
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
        for (int i = 0; i < 4; i++) begin
            clear_all();
            set_req(0, 1'b0, 1'b1, 4'hF, 32'h100, 32'h11111111);
            set_req(1, 1'b0, 1'b1, 4'hF, 32'h200, 32'h22222222);
            #1;
            checks++; if (gnt !== exp_g[i]) begin errors++; $display("FAIL rr_gnt cycle %0d: got %b expected %b", i, gnt, exp_g[i]); end
            checks++; if (mem_addr !== ((exp_g[i] == 2'b01) ? 12'h100 : 12'h200) || mem_wea !== 1'b1)
                begin errors++; $display("FAIL rr_cmd cycle %0d: got addr %h wea %b", i, mem_addr, mem_wea); end
            step();
        end
        clear_all();
    endtask

    task automatic test_single_read();
        clear_all();
        set_req(0, 1'b0, 1'b0, 4'hF, 32'h010, 32'h0);
        #1;
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL read_gnt: got %b expected 01", gnt); end
        checks++; if (mem_en !== 4'hF || mem_wea !== 1'b0 || mem_addr !== 12'h010)
            begin errors++; $display("FAIL read_cmd: got en %h wea %b addr %h expected f 0 010", mem_en, mem_wea, mem_addr); end
        step();
        clear_all();
        #1;
        checks++; if (rvalid !== 2'b01) begin errors++; $display("FAIL read_rvalid: got %b expected 01", rvalid); end
        checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL read_rdata: got %h expected deadbeef", rdata); end
        step();
    endtask

    task automatic test_lock();
        for (int c = 1; c <= 17; c++) begin
            clear_all();
            set_req(1, 1'b1, 1'b1, 4'hF, 32'h300, 32'(c));
            if (c >= 2) set_req(0, 1'b0, 1'b1, 4'hF, 32'h304, 32'hAA);
            #1;
            checks++; if (gnt !== ((c <= 16) ? 2'b10 : 2'b01))
                begin errors++; $display("FAIL lock_gnt cycle %0d: got %b expected %b", c, gnt, (c <= 16) ? 2'b10 : 2'b01); end
            if (c >= 2 && c <= 16) begin
                checks++; if (arb_state !== 1'b1) begin errors++; $display("FAIL lock_state cycle %0d: got %b expected 1", c, arb_state); end
            end
            step();
        end
        clear_all();
        #1;
        checks++; if (arb_state !== 1'b0) begin errors++; $display("FAIL lock_release_state: got %b expected 0", arb_state); end
        step();
    endtask

    task automatic test_oob();
        clear_all();
        set_req(0, 1'b0, 1'b1, 4'hF, 32'hAAAAA008, 32'h12345678);
        #1;
        checks++; if (gnt !== 2'b01 || mem_en !== 4'h0 || mem_addr !== 12'h008)
            begin errors++; $display("FAIL oob_write: got gnt %b en %h addr %h expected 01 0 008", gnt, mem_en, mem_addr); end
        step();
        clear_all();
        set_req(0, 1'b0, 1'b0, 4'hF, 32'hAAAAA008, 32'h0);
        #1;
        checks++; if (gnt !== 2'b01 || mem_en !== 4'h0)
            begin errors++; $display("FAIL oob_read_cmd: got gnt %b en %h expected 01 0", gnt, mem_en); end
        step();
        clear_all();
        #1;
        checks++; if (rvalid !== 2'b01 || rdata !== 32'h0)
            begin errors++; $display("FAIL oob_read_data: got rvalid %b rdata %h expected 01 0", rvalid, rdata); end
        step();
    endtask

    task automatic test_back_to_back();
        clear_all();
        set_req(1, 1'b0, 1'b0, 4'hF, 32'h008, 32'h0);
        #1;
        checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL b2b_gnt1: got %b expected 10", gnt); end
        step();
        clear_all();
        set_req(0, 1'b0, 1'b0, 4'hF, 32'h010, 32'h0);
        #1;
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL b2b_gnt2: got %b expected 01", gnt); end
        checks++; if (rvalid !== 2'b10 || rdata !== 32'h5A5A5A5A)
            begin errors++; $display("FAIL b2b_data1: got rvalid %b rdata %h expected 10 5a5a5a5a", rvalid, rdata); end
        step();
        clear_all();
        #1;
        checks++; if (rvalid !== 2'b01 || rdata !== 32'hDEADBEEF)
            begin errors++; $display("FAIL b2b_data2: got rvalid %b rdata %h expected 01 deadbeef", rvalid, rdata); end
        step();
    endtask

    task automatic test_partial_write();
        clear_all();
        set_req(0, 1'b0, 1'b1, 4'b0011, 32'h020, 32'hCAFEF00D);
        #1;
        checks++; if (gnt !== 2'b01 || mem_en !== 4'b0011 || mem_wea !== 1'b1 || mem_din !== 32'hCAFEF00D)
            begin errors++; $display("FAIL pw_cmd: got gnt %b en %b wea %b din %h", gnt, mem_en, mem_wea, mem_din); end
        step();
        clear_all();
        set_req(1, 1'b0, 1'b0, 4'hF, 32'h020, 32'h0);
        #1;
        checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL pw_read_gnt: got %b expected 10", gnt); end
        step();
        clear_all();
        #1;
        checks++; if (rvalid !== 2'b10 || rdata !== 32'hFFFFF00D)
            begin errors++; $display("FAIL pw_read_data: got rvalid %b rdata %h expected 10 fffff00d", rvalid, rdata); end
        step();
    endtask

    task automatic test_reset_mid();
        clear_all();
        set_req(0, 1'b0, 1'b0, 4'hF, 32'h010, 32'h0);
        #1;
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL rm_gnt: got %b expected 01", gnt); end
        step();
        Rst = 1'b1;
        #1;
        checks++; if (rvalid !== 2'b00 || rdata !== 32'h0)
            begin errors++; $display("FAIL rm_rvalid: got rvalid %b rdata %h expected 00 0", rvalid, rdata); end
        checks++; if (gnt !== 2'b00 || mem_en !== 4'h0)
            begin errors++; $display("FAIL rm_gnt_in_reset: got gnt %b en %h expected 00 0", gnt, mem_en); end
        step();
        Rst = 1'b0;
        clear_all();
        set_req(0, 1'b0, 1'b1, 4'hF, 32'h100, 32'h33333333);
        set_req(1, 1'b0, 1'b1, 4'hF, 32'h200, 32'h44444444);
        #1;
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL rm_contention: got %b expected 01", gnt); end
        checks++; if (rvalid !== 2'b00) begin errors++; $display("FAIL rm_no_late_rvalid: got %b expected 00", rvalid); end
        step();
        clear_all();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_rr_writes();
        test_single_read();
        test_lock();
        test_oob();
        test_back_to_back();
        test_partial_write();
        test_reset_mid();
        repeat (2) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
